// File: rtl/mpeg_pkg.sv
// mpeg_pkg: shared types for the MPEG system-stream path.
// Word bundle for the ES packer and the signed 33-bit time type.
package mpeg_pkg;

   localparam int MPEG_WORD_W = 32;

   typedef struct packed {
      logic [MPEG_WORD_W-1:0] data;
      logic [2:0]             nbytes;
   } es_word_t;

   typedef logic signed [32:0] mpeg_time_t;

endpackage

// File: rtl/mpeg_es_word_fifo.sv
// mpeg_es_word_fifo: synchronous show-ahead FIFO of es_word_t.
// The head word reads as zero while the FIFO is empty.
module mpeg_es_word_fifo
   import mpeg_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               push,
   input  es_word_t           wr_word,
   input  logic               pop,
   output es_word_t           rd_word,
   output logic               empty,
   output logic               full,
   output logic               drop,
   output logic [LEVEL_W-1:0] level
);

   localparam int AW = LEVEL_W - 1;

   es_word_t           mem [DEPTH];
   logic [LEVEL_W-1:0] wr_ptr;
   logic [LEVEL_W-1:0] rd_ptr;
   logic               do_wr;
   logic               do_rd;

   assign level   = wr_ptr - rd_ptr;
   assign empty   = (level == '0);
   assign full    = (level == LEVEL_W'(DEPTH));
   assign do_rd   = pop && !empty && !clear;
   assign do_wr   = push && (!full || do_rd) && !clear;
   assign drop    = push && full && !do_rd && !clear;
   assign rd_word = empty ? '0 : mem[rd_ptr[AW-1:0]];

   // Pointer update; clear empties the FIFO ahead of any push/pop.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; contents need no reset since empty masks the head.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_word;
   end

endmodule

// File: rtl/mpeg_es_packer.sv
// mpeg_es_packer: packs PES payload bytes big-endian into 32-bit words.
// Optional presentation-start gate under MPEG_ES_START_GATE_EN.
module mpeg_es_packer
   import mpeg_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [7:0]           in_data,
   input  logic                 in_valid,
   input  logic                 in_body,
   input  logic                 clear,
   input  logic                 drain,
   output logic [31:0]          out_data,
   output logic [2:0]           out_nbytes,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [LEVEL_W-1:0]   level,
   output logic                 overflow,
   output logic [15:0]          overflow_count,
   input  logic [31:0]          dclk,
   input  logic signed [32:0]   start_time,
   input  logic                 start_valid
);

   logic [31:0] sr;
   logic [31:0] nxt_sr;
   logic [1:0]  idx;
   logic [2:0]  nxt_cnt;
   logic        take;
   logic        push_now;
   logic        push_q;
   es_word_t    push_word_q;
   es_word_t    head;
   logic        fifo_empty;
   logic        unused_fifo_full;
   logic        fifo_drop;
   logic        gate_open;
   logic        pop;

   assign take     = in_valid && in_body;
   assign nxt_cnt  = {1'b0, idx} + {2'b00, take};
   assign push_now = nxt_cnt[2] || (drain && (nxt_cnt != 3'd0));

   // Place the incoming payload byte into its big-endian lane.
   always_comb begin
      nxt_sr = sr;
      if (take) begin
         case (idx)
            2'd0:    nxt_sr[31:24] = in_data;
            2'd1:    nxt_sr[23:16] = in_data;
            2'd2:    nxt_sr[15:8]  = in_data;
            default: nxt_sr[7:0]   = in_data;
         endcase
      end
   end

   // Packer state; a pushed word clears the register so drains pad zeros.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         sr          <= '0;
         idx         <= '0;
         push_q      <= 1'b0;
         push_word_q <= '0;
      end else begin
         push_q <= push_now;
         if (push_now) begin
            push_word_q <= '{data: nxt_sr, nbytes: nxt_cnt};
            sr          <= '0;
            idx         <= '0;
         end else begin
            sr  <= nxt_sr;
            idx <= nxt_cnt[1:0];
         end
      end
   end

   mpeg_es_word_fifo #(
      .DEPTH   (DEPTH),
      .LEVEL_W (LEVEL_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear),
      .push    (push_q),
      .wr_word (push_word_q),
      .pop     (pop),
      .rd_word (head),
      .empty   (fifo_empty),
      .full    (unused_fifo_full),
      .drop    (fifo_drop),
      .level   (level)
   );

   assign pop        = out_ready && gate_open;
   assign out_valid  = !fifo_empty && gate_open;
   assign out_data   = head.data;
   assign out_nbytes = head.nbytes;

   // Drop accounting survives clear; only reset zeroes it.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow       <= 1'b0;
         overflow_count <= '0;
      end else if (fifo_drop) begin
         overflow <= 1'b1;
         if (overflow_count != 16'hFFFF)
            overflow_count <= overflow_count + 16'd1;
      end
   end

`ifdef MPEG_ES_START_GATE_EN
   logic gate_q;
   logic gate_hit;

   assign gate_hit  = start_valid &&
                      ($signed({1'b0, dclk}) >= start_time);
   assign gate_open = gate_q || gate_hit;

   // Gate latches open on the first start-time hit until clear/reset.
   always_ff @(posedge clk) begin
      if (reset || clear)
         gate_q <= 1'b0;
      else if (gate_hit)
         gate_q <= 1'b1;
   end
`else
   logic unused_gate;

   assign unused_gate = ^{dclk, start_time, start_valid};
   assign gate_open   = 1'b1;
`endif

endmodule

// File: tb/tb_mpeg_es_packer.sv
// tb_mpeg_es_packer: directed vector table plus multi-cycle sequences.
// Also exercises the start gate when MPEG_ES_START_GATE_EN is defined.
module tb_mpeg_es_packer;

   logic               clk = 1'b0;
   logic               reset;
   logic [7:0]         in_data;
   logic               in_valid;
   logic               in_body;
   logic               clear;
   logic               drain;
   logic [31:0]        out_data;
   logic [2:0]         out_nbytes;
   logic               out_valid;
   logic               out_ready;
   logic [4:0]         level;
   logic               overflow;
   logic [15:0]        overflow_count;
   logic [31:0]        dclk;
   logic signed [32:0] start_time;
   logic               start_valid;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic        v;
      logic        b;
      logic [7:0]  d;
      logic        dr;
      logic        ev;
      logic [31:0] ed;
      logic [2:0]  en;
      logic [4:0]  el;
   } vec_t;

   vec_t tbl[$];

   mpeg_es_packer #(.DEPTH(16)) dut (
      .clk            (clk),
      .reset          (reset),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_body        (in_body),
      .clear          (clear),
      .drain          (drain),
      .out_data       (out_data),
      .out_nbytes     (out_nbytes),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .level          (level),
      .overflow       (overflow),
      .overflow_count (overflow_count),
      .dclk           (dclk),
      .start_time     (start_time),
      .start_valid    (start_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      in_valid = 1'b0;
      in_body  = 1'b0;
      drain    = 1'b0;
      clear    = 1'b0;
      in_data  = 8'h00;
   endtask

   task automatic put(input logic [7:0] b);
      in_data  = b;
      in_valid = 1'b1;
      in_body  = 1'b1;
      tick();
      idle_in();
   endtask

   task automatic row(input logic v, input logic b, input logic [7:0] d,
                      input logic dr, input logic ev,
                      input logic [31:0] ed, input logic [2:0] en,
                      input logic [4:0] el);
      vec_t r;
      r.v = v; r.b = b; r.d = d; r.dr = dr;
      r.ev = ev; r.ed = ed; r.en = en; r.el = el;
      tbl.push_back(r);
   endtask

   function automatic logic [31:0] wd(input int base);
      logic [7:0] b0, b1, b2, b3;
      b0 = 8'(base);
      b1 = 8'(base + 1);
      b2 = 8'(base + 2);
      b3 = 8'(base + 3);
      return {b0, b1, b2, b3};
   endfunction

   initial begin
      // sync packing, 2-cycle latency
      row(1,1,8'h00,0, 0,32'h0,0,0);
      row(1,1,8'h00,0, 0,32'h0,0,0);
      row(1,1,8'h01,0, 0,32'h0,0,0);
      row(1,1,8'hB3,0, 0,32'h0,0,0);
      row(1,1,8'h12,0, 1,32'h000001B3,4,1);
      row(1,1,8'h34,0, 0,32'h0,0,0);
      row(1,1,8'h56,0, 0,32'h0,0,0);
      row(1,1,8'h78,0, 0,32'h0,0,0);
      row(0,0,8'h00,0, 1,32'h12345678,4,1);
      row(0,0,8'h00,0, 0,32'h0,0,0);
      // body gaps and invalid strobes
      row(1,1,8'hAA,0, 0,32'h0,0,0);
      row(1,0,8'h55,0, 0,32'h0,0,0);
      row(1,1,8'hBB,0, 0,32'h0,0,0);
      row(0,1,8'h66,0, 0,32'h0,0,0);
      row(1,0,8'h77,0, 0,32'h0,0,0);
      row(1,1,8'hCC,0, 0,32'h0,0,0);
      row(1,1,8'hDD,0, 0,32'h0,0,0);
      row(0,0,8'h00,0, 1,32'hAABBCCDD,4,1);
      row(0,0,8'h00,0, 0,32'h0,0,0);
      // drain partial, then empty drain
      row(1,1,8'h11,0, 0,32'h0,0,0);
      row(1,1,8'h22,0, 0,32'h0,0,0);
      row(1,1,8'h33,0, 0,32'h0,0,0);
      row(0,0,8'h00,1, 0,32'h0,0,0);
      row(0,0,8'h00,0, 1,32'h11223300,3,1);
      row(0,0,8'h00,1, 0,32'h0,0,0);
      row(0,0,8'h00,0, 0,32'h0,0,0);
      row(0,0,8'h00,0, 0,32'h0,0,0);
      // drain with completing byte: one full word only
      row(1,1,8'h44,0, 0,32'h0,0,0);
      row(1,1,8'h55,0, 0,32'h0,0,0);
      row(1,1,8'h66,0, 0,32'h0,0,0);
      row(1,1,8'h77,1, 0,32'h0,0,0);
      row(0,0,8'h00,0, 1,32'h44556677,4,1);
      row(0,0,8'h00,0, 0,32'h0,0,0);
      row(0,0,8'h00,0, 0,32'h0,0,0);
      // drain with non-completing byte
      row(1,1,8'h88,0, 0,32'h0,0,0);
      row(1,1,8'h99,1, 0,32'h0,0,0);
      row(0,0,8'h00,0, 1,32'h88990000,2,1);
      row(0,0,8'h00,0, 0,32'h0,0,0);

      idle_in();
      out_ready   = 1'b1;
      dclk        = 32'd2000;
      start_time  = 33'sd1000;
      start_valid = 1'b1;
      reset       = 1'b1;
      tick();
      tick();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", out_data, 32'd0);
      chk("rst_nbytes", 32'(out_nbytes), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_ovf_cnt", 32'(overflow_count), 32'd0);
      reset = 1'b0;

      foreach (tbl[i]) begin
         in_valid = tbl[i].v;
         in_body  = tbl[i].b;
         in_data  = tbl[i].d;
         drain    = tbl[i].dr;
         tick();
         chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
         chk($sformatf("vec%0d_data", i), out_data, tbl[i].ed);
         chk($sformatf("vec%0d_nbytes", i), 32'(out_nbytes),
             32'(tbl[i].en));
         chk($sformatf("vec%0d_level", i), 32'(level), 32'(tbl[i].el));
      end
      idle_in();

      // overflow: 18 words into a 16-deep FIFO
      out_ready = 1'b0;
      for (int k = 0; k < 72; k++) put(8'(k));
      tick();
      tick();
      chk("ovf_level", 32'(level), 32'd16);
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_count", 32'(overflow_count), 32'd2);
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("ovf_rd%0d_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("ovf_rd%0d_data", i), out_data, wd(4 * i));
         tick();
      end
      chk("ovf_empty_valid", 32'(out_valid), 32'd0);
      chk("ovf_empty_level", 32'(level), 32'd0);

      // push and pop on the same edge while full: nothing dropped
      out_ready = 1'b0;
      for (int k = 0; k < 64; k++) put(8'(8'h80 + k));
      tick();
      tick();
      chk("full2_level", 32'(level), 32'd16);
      put(8'hC0);
      put(8'hC1);
      put(8'hC2);
      put(8'hC3);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("full_pp_level", 32'(level), 32'd16);
      chk("full_pp_count", 32'(overflow_count), 32'd2);
      chk("full_pp_head", out_data, 32'h84858687);

      // clear empties FIFO but keeps drop accounting
      clear    = 1'b1;
      in_data  = 8'hEE;
      in_valid = 1'b1;
      in_body  = 1'b1;
      tick();
      idle_in();
      chk("clr_level", 32'(level), 32'd0);
      chk("clr_valid", 32'(out_valid), 32'd0);
      chk("clr_ovf", 32'(overflow), 32'd1);
      chk("clr_count", 32'(overflow_count), 32'd2);

      // clear discards a partial word and its same-cycle byte
      put(8'hE0);
      put(8'hE1);
      put(8'hE2);
      clear    = 1'b1;
      in_data  = 8'hE3;
      in_valid = 1'b1;
      in_body  = 1'b1;
      tick();
      idle_in();
      put(8'hF0);
      put(8'hF1);
      put(8'hF2);
      put(8'hF3);
      tick();
      chk("clr_pk_valid", 32'(out_valid), 32'd1);
      chk("clr_pk_data", out_data, 32'hF0F1F2F3);
      chk("clr_pk_level", 32'(level), 32'd1);
      out_ready = 1'b1;
      tick();

      // reset mid-stream restarts in lane 3 and zeroes counters
      put(8'h11);
      put(8'h22);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mrst_ovf", 32'(overflow), 32'd0);
      chk("mrst_count", 32'(overflow_count), 32'd0);
      chk("mrst_level", 32'(level), 32'd0);
      out_ready = 1'b0;
      put(8'hA1);
      put(8'hA2);
      put(8'hA3);
      put(8'hA4);
      tick();
      chk("mrst_data", out_data, 32'hA1A2A3A4);
      chk("mrst_nbytes", 32'(out_nbytes), 32'd4);
      out_ready = 1'b1;
      tick();
      chk("mrst_pop_level", 32'(level), 32'd0);

`ifdef MPEG_ES_START_GATE_EN
      start_valid = 1'b0;
      clear       = 1'b1;
      tick();
      idle_in();
      start_valid = 1'b1;
      start_time  = 33'sd1000;
      dclk        = 32'd990;
      for (int k = 1; k <= 8; k++) put(8'(k));
      tick();
      tick();
      chk("gate_closed_valid", 32'(out_valid), 32'd0);
      chk("gate_closed_level", 32'(level), 32'd2);
      for (int d = 991; d < 1000; d++) begin
         dclk = 32'(d);
         #1;
         chk($sformatf("gate_ramp%0d", d), 32'(out_valid), 32'd0);
         tick();
      end
      dclk = 32'd1000;
      #1;
      chk("gate_open_valid", 32'(out_valid), 32'd1);
      chk("gate_open_w0", out_data, 32'h01020304);
      tick();
      dclk = 32'd0;
      #1;
      chk("gate_latch_valid", 32'(out_valid), 32'd1);
      chk("gate_latch_w1", out_data, 32'h05060708);
      tick();
      chk("gate_drained", 32'(level), 32'd0);
      clear = 1'b1;
      tick();
      idle_in();
      for (int k = 0; k < 4; k++) put(8'(8'h30 + k));
      tick();
      tick();
      chk("gate_reclosed_valid", 32'(out_valid), 32'd0);
      chk("gate_reclosed_level", 32'(level), 32'd1);
`else
      start_valid = 1'b1;
      start_time  = 33'sd1000;
      dclk        = 32'd0;
      out_ready   = 1'b0;
      for (int k = 0; k < 4; k++) put(8'(8'h30 + k));
      tick();
      chk("nogate_valid", 32'(out_valid), 32'd1);
      chk("nogate_data", out_data, 32'h30313233);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mpeg_es_packer.md
Name: mpeg_es_packer

Overview:
- Sits directly downstream of the MPEG system-stream demuxer and consumes the same byte stream it sees.
- Captures only PES payload bytes: those flagged by the demuxer's packet-body indication for the selected stream.
- Packs them big-endian into 32-bit words and buffers them in a word FIFO.
- Presents the words to the audio/video decoder over a valid/ready interface, with overflow accounting and an optional presentation-start gate.

Parameters:
- DEPTH, 16, FIFO depth in 32-bit words; power of two, at least 4.
- LEVEL_W, $clog2(DEPTH)+1, width of the fill-level output.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_data  in  8  byte stream, same bus that feeds the demuxer
- in_valid  in  1  byte strobe, same as the demuxer data_valid
- in_body  in  1  demuxer packet-body flag; a byte is payload iff in_valid && in_body in the same cycle
- clear  in  1  synchronous clear of packer, FIFO and gate; counters are kept
- drain  in  1  push any partial word, zero-padded
- out_data  out  32  payload word; first captured byte in [31:24]
- out_nbytes  out  3  valid bytes in out_data, 1..4; less than 4 only for a drained word
- out_valid  out  1  word available
- out_ready  in  1  consumer accepts the word when out_valid && out_ready
- level  out  LEVEL_W  FIFO occupancy in words
- overflow  out  1  sticky, set on any dropped word; cleared by reset only
- overflow_count  out  16  dropped words, saturating at 16'hFFFF; cleared by reset only
- dclk  in  32  45 kHz timebase (used by the optional feature only)
- start_time  in  33 signed  presentation start time from the demuxer (optional feature only)
- start_valid  in  1  start_time valid (optional feature only)

Behaviour:
- Reset values: all outputs 0; byte index 0; FIFO empty; gate closed.
- Packer: 32-bit shift register plus a 2-bit byte index.
  - Each payload byte is written to lane 3-idx, then idx increments.
  - When idx wraps 3->0, the word is pushed with nbytes=4.
  - Packing continues across PES packet boundaries; a falling in_body does not flush.
- Drain:
  - idx>0 -> push {captured bytes, zero pad}, nbytes=idx; idx returns to 0.
  - idx==0 -> nothing is pushed.
  - A payload byte in the same cycle as drain is included first. If that byte completes a word, exactly one word (nbytes=4) is pushed.
- Latency:
  - The completing byte in cycle N is registered at the edge ending cycle N.
  - The FIFO write happens at the edge ending cycle N+1.
  - out_valid rises in cycle N+2 if the FIFO was empty and the gate is open.
- Throughput: one byte per cycle in; one word per cycle out.
- FIFO behaviour:
  - Standard synchronous FIFO with show-ahead output: out_data/out_nbytes always reflect the head entry.
  - Pointers are LEVEL_W bits wide and wrap naturally.
  - level = wr_ptr - rd_ptr.
- Full: a push while level==DEPTH and no pop in the same cycle drops the word, sets overflow and increments overflow_count (saturating).
  - A push and a pop in the same cycle while full both succeed.
- Empty: out_valid=0; out_ready is ignored.
- clear: has priority over every other input in that cycle.
  - Empties the FIFO, zeroes idx and the shift register, and closes the gate.
  - The byte presented in that cycle is discarded.
  - overflow and overflow_count are not affected.
- Reset mid-stream: all state returns to reset values; the next payload byte starts a fresh word in lane 3.
- No state machine beyond the idx counter and the gate flag; the FIFO pointers are the only other sequential control.

Optional Feature:
- Macro: MPEG_ES_START_GATE_EN.
- With the macro:
  - A gate flag opens on the first cycle where start_valid && $signed({1'b0,dclk}) >= start_time (33-bit signed compare).
  - The gate stays open until clear/reset.
  - While closed, out_valid is forced 0 and no pops occur; capture and overflow accounting continue normally.
- Without the macro: the gate is permanently open; dclk, start_time and start_valid are present but ignored.

Decomposition:
- Shared package mpeg_pkg:
  - MPEG_WORD_W=32.
  - typedef es_word_t {logic [31:0] data; logic [2:0] nbytes;}.
  - typedef mpeg_time_t as signed 33-bit (also usable by the demuxer's start-time output).
- Sub-module mpeg_es_word_fifo: generic synchronous show-ahead FIFO of es_word_t, parameterised by DEPTH. It exports level, a full flag and a drop strobe.
- The packer, drain logic, counters and gate live in mpeg_es_packer.

Test Plan:
- Eight payload bytes 00 00 01 B3 12 34 56 78, in_body=1, out_ready=1 -> words 000001B3 then 12345678, both nbytes=4. First out_valid appears 2 cycles after the 4th byte.
- Bytes with in_body=0 interleaved among AA BB CC DD -> only the in_body=1 bytes are packed. Packing spans a body gap.
- Bytes 11 22 33, then drain -> word 11223300, nbytes=3. A second drain with nothing pending -> no word.
- out_ready=0 with DEPTH=16: push 18 words -> level=16, overflow=1, overflow_count=2. Draining then yields the first 16 words in order.
- Full FIFO with out_ready=1 while a word completes in the same cycle -> no drop, level stays 16.
- MPEG_ES_START_GATE_EN with start_time=1000, start_valid=1, dclk ramping from 990 -> out_valid stays low until dclk=1000, then queued words stream out. clear closes the gate again.
